regfile_bypass: RTL
===================

# regfile_bypass

Parametrised successor to the pipeline register file: NUM_REGS × DATA_WIDTH storage with synchronous reset, two combinational read ports with same-cycle write-through bypass, a per-register busy scoreboard for hazard detection, and a synchronised, edge-detected external trigger that writes a fixed value into a chosen register. Sits in the decode stage; reads feed the ID/EX register, writes come from writeback, issue marks come from decode.

## Interface
- DATA_WIDTH, 32, register width
- ADDR_WIDTH, 5, register address width; NUM_REGS = 2**ADDR_WIDTH
- TRIG_REG, 5, register written on trigger edge (never 0)
- TRIG_VALUE, 1, value written on trigger edge (DATA_WIDTH wide)
- A0_REG, 10, register exposed on a0

- clk  in  1  clock, all state updates on posedge
- rst  in  1  synchronous, active-high reset
- RegWrite  in  1  writeback enable
- rd  in  ADDR_WIDTH  writeback address
- WD3  in  DATA_WIDTH  writeback data
- rs1, rs2  in  ADDR_WIDTH  read addresses
- issue_valid  in  1  decode issues an instruction with destination issue_rd
- issue_rd  in  ADDR_WIDTH  destination of issued instruction
- trigger  in  1  asynchronous external input
- RD1D, RD2D  out  DATA_WIDTH  read data
- busy1, busy2  out  1  scoreboard bit of rs1 / rs2
- a0  out  DATA_WIDTH  stored content of A0_REG
- trig_pending  out  1  trigger write waiting to commit

## Operation
- Storage: reg[0] reads 0 always; writes to address 0 ignored (no storage update, no bypass, no busy set).
- Write: RegWrite && rd!=0 → reg[rd] <= WD3 at posedge.
- Read: RDxD = WD3 if RegWrite && rd==rsx && rd!=0, else reg[rsx]. Pure combinational.
- a0 = reg[A0_REG] stored value, no bypass.
- Scoreboard busy[NUM_REGS]: issue_valid && issue_rd!=0 sets busy[issue_rd]; RegWrite && rd!=0 clears busy[rd]. Same cycle, same address: set wins (newer instruction). busyx = busy[rsx], except busyx=0 when RegWrite && rd==rsx (value is being bypassed) unless also issued same cycle to that address, in which case busyx=1 from the next cycle only (combinational output uses pre-edge state, bypass overrides).
- Trigger: two-flop synchroniser s1,s2, plus s3 for edge detect; edge = s2 && !s3. edge sets pend.
- Commit: when pend=1 and NOT (RegWrite && rd==TRIG_REG) → reg[TRIG_REG] <= TRIG_VALUE, pend cleared. Writeback to TRIG_REG has priority; trigger commit deferred one or more cycles. Writes to other registers do not block commit.
- Edge arriving while pend=1 merges (single write). Trigger commit does not alter busy.
- trig_pending = pend.

## Timing
- Reset (rst=1 at posedge): all registers 0, busy all 0, s1/s2/s3=0, pend=0. After reset: RD1D/RD2D=0 (absent bypass), a0=0, busy1/busy2=0, trig_pending=0. rst dominates all writes, issues and trigger commits in that cycle; a trigger edge in progress through the synchroniser is discarded.
- Read latency 0 cycles; write visible via bypass same cycle, via storage from next cycle.
- Trigger: rising trigger sampled at edge N → s1 at N, s2 at N+1, edge detected during cycle after N+1, pend=1 after N+2, reg[TRIG_REG]=TRIG_VALUE after N+3 if unblocked. Minimum 3 edges plus one commit edge; trigger held high longer produces one write only. Trigger must be low for ≥2 cycles between pulses to register a new edge.
- Busy set visible one cycle after issue edge; clear visible same cycle via bypass masking, in storage next cycle.

## Test plan
- Reset: write 0xDEADBEEF to x7, assert rst one cycle → rs1=7 reads 0, a0=0, busy all 0, trig_pending=0.
- Bypass: RegWrite=1, rd=3, WD3=0x12345678, rs1=3, rs2=0 same cycle → RD1D=0x12345678, RD2D=0; next cycle with RegWrite=0 RD1D still 0x12345678. rd=0 write of 0xFFFFFFFF → x0 reads 0.
- Scoreboard: issue rd=4 → busy1=1 for rs1=4 next cycle; writeback rd=4 data 0x55 → busy1=0 and RD1D=0x55 same cycle; simultaneous issue and writeback rd=4 → busy stays 1.
- Trigger latency: pulse trigger high 1 cycle after reset → trig_pending rises after 3rd edge, x5=1 and a0 unaffected after 4th edge; holding trigger high 10 cycles yields exactly one write.
- Trigger conflict: pend=1 with RegWrite rd=5 WD3=0x99 for 2 consecutive cycles → x5=0x99, pend held; third cycle no write → x5=1, pend=0.
- Reset mid-trigger: trigger rises, rst asserted at the cycle pend would set → pend=0, x5=0, no later write.

Source files
------------

// File: rtl/regfile_bypass.sv
// Decode-stage register file: write-through bypass on both read ports, a busy
// scoreboard for hazard detection and a synchronised trigger that writes a fixed value.
module regfile_bypass #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 5,
  parameter int                    TRIG_REG   = 5,
  parameter logic [DATA_WIDTH-1:0] TRIG_VALUE = {{(DATA_WIDTH-1){1'b0}}, 1'b1},
  parameter int                    A0_REG     = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RegWrite,
  input  logic [ADDR_WIDTH-1:0] rd,
  input  logic [DATA_WIDTH-1:0] WD3,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  input  logic                  trigger,
  output logic [DATA_WIDTH-1:0] RD1D,
  output logic [DATA_WIDTH-1:0] RD2D,
  output logic                  busy1,
  output logic                  busy2,
  output logic [DATA_WIDTH-1:0] a0,
  output logic                  trig_pending
);

  localparam int                    NUM_REGS  = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] TRIG_ADDR = ADDR_WIDTH'(TRIG_REG);
  localparam logic [ADDR_WIDTH-1:0] A0_ADDR   = ADDR_WIDTH'(A0_REG);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0]   busy;
  logic                  s1, s2, s3;
  logic                  pend;
  logic                  wb_en;
  logic                  issue_en;
  logic                  trig_edge;
  logic                  trig_commit;

  assign wb_en       = RegWrite && (rd != '0);
  assign issue_en    = issue_valid && (issue_rd != '0);
  assign trig_edge   = s2 && !s3;
  // A writeback to the trigger register wins; the trigger write waits for a free cycle.
  assign trig_commit = pend && !(RegWrite && (rd == TRIG_ADDR));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (wb_en) begin
        regs[rd] <= WD3;
      end
      if (trig_commit) begin
        regs[TRIG_ADDR] <= TRIG_VALUE;
      end
    end
  end

  // Clear first, then set, so a same-cycle issue to the written register stays busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      if (wb_en) begin
        busy[rd] <= 1'b0;
      end
      if (issue_en) begin
        busy[issue_rd] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s3   <= 1'b0;
      pend <= 1'b0;
    end else begin
      s1   <= trigger;
      s2   <= s1;
      s3   <= s2;
      pend <= trig_commit ? 1'b0 : (pend || trig_edge);
    end
  end

  always_comb begin
    RD1D  = (rs1 == '0) ? '0 : regs[rs1];
    busy1 = busy[rs1];
    if (wb_en && (rd == rs1)) begin
      RD1D  = WD3;
      busy1 = 1'b0;
    end
    RD2D  = (rs2 == '0) ? '0 : regs[rs2];
    busy2 = busy[rs2];
    if (wb_en && (rd == rs2)) begin
      RD2D  = WD3;
      busy2 = 1'b0;
    end
  end

  assign a0           = regs[A0_ADDR];
  assign trig_pending = pend;

endmodule
